ex_muldiv_unit: RTL
===================

// Module: ex_muldiv_unit
// PURPOSE
//   Iterative RV32M multiply/divide unit in the EX stage, fed by the ID/EX pipeline register.
//   Accepts one M-extension op, computes it over multiple cycles, and stalls the pipeline meanwhile.
//   Delivers the 32-bit result with its destination register to the EX/MEM path.
//   Radix-2: one shift-add (MUL*) or one restoring-subtract (DIV*/REM*) step per cycle.
// PARAMETERS
//   WIDTH   32  operand/result width; only 32 is supported
//   CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk_i       in   1   clock, rising edge
//   rst_n_i     in   1   asynchronous reset, active low
//   valid_i     in   1   op present; sampled only while state is IDLE
//   flush_i     in   1   abort current op (branch/exception); has priority over valid_i
//   funct3_i    in   3   M-ext op: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//   rs1_i       in   32  operand A (post-forwarding)
//   rs2_i       in   32  operand B (post-forwarding)
//   rd_addr_i   in   5   destination register
//   busy_o      out  1   stall request to PC/IF-ID/ID-EX; high in CALC and DONE
//   done_o      out  1   one-cycle result-valid pulse
//   result_o    out  32  result; valid only while done_o=1
//   rd_addr_o   out  5   destination captured at accept
// BEHAVIOUR
//   Reset (async, rst_n_i=0): state=IDLE; busy_o=0, done_o=0, result_o=0, rd_addr_o=0,
//     counter and all datapath registers 0.
//   States: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: on an edge with valid_i=1 and flush_i=0, latch the operands, funct3 and rd_addr (accept).
//     Signed ops: take the magnitude of each signed operand and record the result sign.
//     Set counter=0 and go to CALC. With valid_i=0, stay in IDLE.
//   CALC: one iteration per edge, counter+1.
//     After the 32nd iteration (counter reaches 31 and wraps), go to DONE.
//   DONE: done_o=1 for exactly one cycle; result_o holds the sign-corrected result; then IDLE.
//   Latency: accept edge E0; done_o high after edge E33 (E0 + 33 edges); busy_o falls on the next edge.
//     A new op can be accepted on the edge that leaves DONE only if valid_i=1 then.
//     Since busy_o was high, that is the next instruction.
//   Result select:
//     MUL                 -> product[31:0]
//     MULH/MULHSU/MULHU   -> product[63:32]; MULHSU is rs1 signed, rs2 unsigned
//     DIV/DIVU            -> quotient
//     REM/REMU            -> remainder; sign follows the dividend
//   Fast paths (accept -> DONE directly, done_o after E1, no CALC):
//     divisor==0: quotient=32'hFFFF_FFFF, remainder=rs1
//     DIV/REM with rs1=32'h8000_0000 and rs2=32'hFFFF_FFFF: quotient=32'h8000_0000, remainder=0
//   valid_i while busy_o=1: ignored; the upstream stage is held by busy_o.
//   flush_i=1 on any edge: state=IDLE, done_o=0, busy_o=0, result discarded.
//     A flush coincident with DONE suppresses done_o.
//   Reset asserted mid-op: immediate IDLE; no done_o after release.
//   Arithmetic: 64-bit product accumulator; 33-bit partial remainder for restoring division.
//     Two's-complement negation is applied at DONE when the recorded sign is negative.
// CONFIGURATION
//   MULDIV_EARLY_OUT_EN defined: MUL* ops exit CALC to DONE at the first edge on which the
//     remaining shifted multiplier bits are all zero; latency is 2 + (bit index of the
//     multiplier's highest set bit), and a multiplier of 0 takes 2 edges.
//     DIV* ops are unchanged.
//   Not defined: every non-fast-path op takes exactly 32 CALC cycles, so done_o always
//     follows E33.
// TESTING
//   MUL rs1=7, rs2=-3 (32'hFFFF_FFFD) -> done_o after E33, result_o=32'hFFFF_FFEB, rd_addr_o=captured.
//   MULHU rs1=rs2=32'hFFFF_FFFF -> 32'hFFFF_FFFE; MULH of same -> 0; MULHSU rs1=-1, rs2=2 -> 32'hFFFF_FFFF.
//   DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//   DIVU 5/0 -> 32'hFFFF_FFFF; REM 5/0 -> 5; DIV 32'h8000_0000 / -1 -> 32'h8000_0000.
//     All three fast paths: done_o after E1.
//   flush_i pulse at E10 of a DIV -> IDLE, no done_o, busy_o low after E10.
//     Reset asserted at E5 -> all outputs 0 immediately.
//   valid_i held high with new operands throughout CALC -> ignored; the second op is accepted
//     on the edge leaving DONE.
//     With MULDIV_EARLY_OUT_EN: MUL rs2=1 -> done_o after E2.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_muldiv_unit: iterative radix-2 RV32M multiply/divide unit (EX stage). Rev 1.0
// Optional: define MULDIV_EARLY_OUT_EN to end MUL* ops once the multiplier is used up.
// ----------------------------------------------------------------------------
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  input  logic [4:0]       rd_addr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       rd_addr_o
);

  localparam logic [WIDTH-1:0] INT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           op_q;
  logic [4:0]           rd_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     dsr_q;

  // Operand decode at accept time
  logic             a_signed;
  logic             b_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             res_neg_in;
  logic             div_by_zero;
  logic             div_ovf;
  logic             fast_path;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_neg       = a_signed & rs1_i[WIDTH-1];
  assign b_neg       = b_signed & rs2_i[WIDTH-1];
  assign a_mag       = a_neg ? -rs1_i : rs1_i;
  assign b_mag       = b_neg ? -rs2_i : rs2_i;
  // Remainder takes the dividend's sign; everything else the product of signs.
  assign res_neg_in  = (funct3_i[2] & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
  assign div_by_zero = (rs2_i == '0);
  assign div_ovf     = ~funct3_i[0] & (rs1_i == INT_MIN) & (rs2_i == '1);
  assign fast_path   = funct3_i[2] & (div_by_zero | div_ovf);

  // Restoring division step
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_trial;
  logic           rem_ge;

  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_trial = rem_shift - {1'b0, dsr_q};
  assign rem_ge    = ~rem_trial[WIDTH];

  logic early_exit;
`ifdef MULDIV_EARLY_OUT_EN
  assign early_exit = ~op_q[2] & ~|mplier_q[WIDTH-1:1];
`else
  assign early_exit = 1'b0;
`endif

  // Sign correction and result select
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   final_res;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -quo_q : quo_q;
  assign rem_fix  = neg_q ? -rem_q : rem_q;

  always_comb begin
    final_res = '0;
    if (op_q[2]) begin
      final_res = op_q[1] ? rem_fix : quo_fix;
    end else if (op_q[1:0] == 2'b00) begin
      final_res = prod_fix[WIDTH-1:0];
    end else begin
      final_res = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      result_o  <= '0;
      rd_addr_o <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
    end else if (flush_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_o <= 1'b0;
      if (state == DONE) begin
        done_o    <= 1'b1;
        result_o  <= final_res;
        rd_addr_o <= rd_q;
      end
      case (state)
        // The edge leaving DONE may also accept the next op.
        IDLE, DONE: begin
          busy_o <= valid_i | (state == DONE);
          state  <= IDLE;
          if (valid_i) begin
            state    <= fast_path ? DONE : CALC;
            op_q     <= funct3_i;
            rd_q     <= rd_addr_i;
            cnt_q    <= '0;
            neg_q    <= fast_path ? 1'b0 : res_neg_in;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            dsr_q    <= b_mag;
            if (fast_path) begin
              rem_q <= div_by_zero ? rs1_i : '0;
              quo_q <= div_by_zero ? '1 : INT_MIN;
            end else begin
              rem_q <= '0;
              quo_q <= a_mag;
            end
          end
        end
        CALC: begin
          busy_o <= 1'b1;
          if (op_q[2]) begin
            rem_q <= rem_ge ? rem_trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], rem_ge};
          end else begin
            acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER || early_exit) begin
            cnt_q <= '0;
            state <= DONE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
